// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input conditioner.
//   JOY_R/L/D/U   : direction bit positions inside one 16-bit hps_io joystick word
//   mode_e        : stick routing mode (shared pad, independent, cocktail)
//   coin_state_e  : coin pulse FSM states
//   mirror_dirs() : swaps U<->D and L<->R for a flipped cocktail player
package arcade_input_pkg;

  localparam int JOY_R = 0;
  localparam int JOY_L = 1;
  localparam int JOY_D = 2;
  localparam int JOY_U = 3;

  typedef enum logic [1:0] {
    MODE_SHARED   = 2'd0,
    MODE_INDEP    = 2'd1,
    MODE_COCKTAIL = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    COIN_IDLE  = 2'd0,
    COIN_PULSE = 2'd1,
    COIN_GAP   = 2'd2
  } coin_state_e;

  function automatic logic [15:0] mirror_dirs(input logic [15:0] w);
    logic [15:0] r;
    r        = w;
    r[JOY_R] = w[JOY_L];
    r[JOY_L] = w[JOY_R];
    r[JOY_D] = w[JOY_U];
    r[JOY_U] = w[JOY_D];
    return r;
  endfunction

endpackage

// File: rtl/arcade_input_cond_coin_pulser.sv
// Per-player coin conditioner: debounces the raw coin bit, then emits a
// fixed-width active-low pulse followed by an equal-length gap. One extra
// coin arriving while busy is remembered and replayed after the gap.
//   clk_sys    : clock
//   reset_n    : async active-low reset
//   coin_raw_i : raw (already mode-routed) coin bit, active-high
//   coin_n_o   : active-low coin pulse, registered
//   busy_o     : 1 while the FSM is in PULSE or GAP
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = 1024,
  parameter int COIN_PULSE_CYC = 200000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic coin_raw_i,
  output logic coin_n_o,
  output logic busy_o
);

  localparam int DBW = $clog2(DEBOUNCE_CYC) + 1;
  localparam int CPW = $clog2(COIN_PULSE_CYC) + 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [CPW-1:0] CP_LAST = CPW'(COIN_PULSE_CYC - 1);

  logic [DBW-1:0] db_cnt_q;
  logic           stable_q;
  logic           db_hit;
  logic           rise;

  // rise fires on the same edge that commits the debounced 0->1 change,
  // so the FSM reacts without an extra edge-detect register.
  assign db_hit = (coin_raw_i != stable_q) && (db_cnt_q == DB_LAST);
  assign rise   = db_hit & coin_raw_i;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt_q <= '0;
      stable_q <= 1'b0;
    end else if (coin_raw_i == stable_q) begin
      db_cnt_q <= '0;
    end else if (db_hit) begin
      db_cnt_q <= '0;
      stable_q <= coin_raw_i;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  coin_state_e    state_q;
  logic [CPW-1:0] cnt_q;
  logic           pend_q;
  logic           coin_n_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= COIN_IDLE;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      coin_n_q <= 1'b1;
    end else begin
      case (state_q)
        COIN_IDLE: begin
          if (rise) begin
            state_q  <= COIN_PULSE;
            cnt_q    <= '0;
            coin_n_q <= 1'b0;
          end
        end
        COIN_PULSE: begin
          if (rise) pend_q <= 1'b1;
          if (cnt_q == CP_LAST) begin
            state_q  <= COIN_GAP;
            cnt_q    <= '0;
            coin_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        COIN_GAP: begin
          if (cnt_q == CP_LAST) begin
            cnt_q <= '0;
            if (pend_q || rise) begin
              state_q  <= COIN_PULSE;
              coin_n_q <= 1'b0;
              // A rise landing on the replay edge refills the pending slot.
              pend_q   <= pend_q & rise;
            end else begin
              state_q <= COIN_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (rise) pend_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= COIN_IDLE;
          cnt_q    <= '0;
          pend_q   <= 1'b0;
          coin_n_q <= 1'b1;
        end
      endcase
    end
  end

  assign coin_n_o = coin_n_q;
  assign busy_o   = (state_q != COIN_IDLE);

endmodule

// File: rtl/arcade_input_cond.sv
// Arcade control conditioner: hps_io joystick words in, active-low core
// player inputs out. Routes pads per mode, registers directions, debounces
// buttons/start, adds per-player autofire on button 0 and shapes coin pulses.
//   clk_sys       : clock, reset_n : async active-low reset
//   joy_i         : player p word at [16p +: 16], bit0 R, 1 L, 2 D, 3 U
//   mode_i        : 0 shared, 1 independent, 2 cocktail, 3 independent
//   autofire_en_i : per-player autofire enable for button 0
//   dir_n_o       : player p at [4p +: 4], same bit order as joy (bit0 R)
//   btn_n_o       : player p at [NUM_BUTTONS*p +: NUM_BUTTONS]
//   start_n_o, coin_n_o, coin_busy_o : one bit per player
module arcade_input_cond
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS    = 2,
  parameter int NUM_BUTTONS    = 1,
  parameter int START_BIT      = 5,
  parameter int COIN_BIT       = 7,
  parameter int DEBOUNCE_CYC   = 1024,
  parameter int COIN_PULSE_CYC = 200000,
  parameter int AUTOFIRE_DIV   = 400000
) (
  input  logic                               clk_sys,
  input  logic                               reset_n,
  input  logic [16*NUM_PLAYERS-1:0]          joy_i,
  input  logic [1:0]                         mode_i,
  input  logic [NUM_PLAYERS-1:0]             autofire_en_i,
  output logic [4*NUM_PLAYERS-1:0]           dir_n_o,
  output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] btn_n_o,
  output logic [NUM_PLAYERS-1:0]             start_n_o,
  output logic [NUM_PLAYERS-1:0]             coin_n_o,
  output logic [NUM_PLAYERS-1:0]             coin_busy_o
);

  localparam int NBIT = NUM_BUTTONS + 1;  // fire buttons plus start
  localparam int DBW  = $clog2(DEBOUNCE_CYC) + 1;
  localparam int AFW  = $clog2(AUTOFIRE_DIV) + 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [AFW-1:0] AF_LAST = AFW'(AUTOFIRE_DIV - 1);

  mode_e                         mode;
  logic [15:0]                   joy_or;
  logic [NUM_PLAYERS-1:0][15:0]  src;

  assign mode = mode_e'(mode_i);

  // Combinational routing; everything downstream is registered, so a mode
  // change shows up one edge later and cannot glitch longer than a cycle.
  always_comb begin
    joy_or = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) joy_or |= joy_i[16*p +: 16];
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      src[p] = joy_i[16*p +: 16];
      case (mode)
        MODE_SHARED:   src[p] = joy_or;
        MODE_COCKTAIL: if (p > 0) src[p] = mirror_dirs(joy_i[16*p +: 16]);
        default: ;
      endcase
    end
  end

  logic unused_src;
  assign unused_src = ^src;

  logic [4*NUM_PLAYERS-1:0] dir_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) dir_q <= '1;
    else for (int p = 0; p < NUM_PLAYERS; p++) dir_q[4*p +: 4] <= ~src[p][3:0];
  end

  assign dir_n_o = dir_q;

  logic [NUM_PLAYERS-1:0][NBIT-1:0] deb_q;
  logic [NUM_PLAYERS-1:0][NBIT-1:0] deb_rise;

  for (genvar gp = 0; gp < NUM_PLAYERS; gp++) begin : g_pl
    logic [AFW-1:0] af_cnt_q;
    logic           af_ph_q;
    logic           af_fire;

    // A fresh press restarts the divider in the firing phase so the first
    // shot is immediate; release parks it back in that phase.
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        af_cnt_q <= '0;
        af_ph_q  <= 1'b1;
      end else if (deb_rise[gp][0]) begin
        af_cnt_q <= '0;
        af_ph_q  <= 1'b1;
      end else if (deb_q[gp][0]) begin
        if (af_cnt_q == AF_LAST) begin
          af_cnt_q <= '0;
          af_ph_q  <= ~af_ph_q;
        end else begin
          af_cnt_q <= af_cnt_q + 1'b1;
        end
      end else begin
        af_cnt_q <= '0;
        af_ph_q  <= 1'b1;
      end
    end

    assign af_fire = autofire_en_i[gp] ? (deb_q[gp][0] & af_ph_q) : deb_q[gp][0];

    for (genvar gb = 0; gb < NBIT; gb++) begin : g_bit
      logic           raw;
      logic           hit;
      logic           stable_q;
      logic [DBW-1:0] cnt_q;
      logic           pressed;
      logic           out_q;

      assign raw = (gb < NUM_BUTTONS) ? src[gp][4+gb] : src[gp][START_BIT];
      assign hit = (raw != stable_q) && (cnt_q == DB_LAST);
      assign deb_q[gp][gb]    = stable_q;
      assign deb_rise[gp][gb] = hit & raw;

      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q    <= '0;
          stable_q <= 1'b0;
        end else if (raw == stable_q) begin
          cnt_q <= '0;
        end else if (hit) begin
          cnt_q    <= '0;
          stable_q <= raw;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign pressed = (gb == 0) ? af_fire : stable_q;

      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) out_q <= 1'b1;
        else          out_q <= ~pressed;
      end

      if (gb < NUM_BUTTONS) begin : g_btn
        assign btn_n_o[NUM_BUTTONS*gp + gb] = out_q;
      end else begin : g_start
        assign start_n_o[gp] = out_q;
      end
    end

    coin_pulser #(
      .DEBOUNCE_CYC  (DEBOUNCE_CYC),
      .COIN_PULSE_CYC(COIN_PULSE_CYC)
    ) u_coin (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .coin_raw_i(src[gp][COIN_BIT]),
      .coin_n_o  (coin_n_o[gp]),
      .busy_o    (coin_busy_o[gp])
    );
  end

endmodule

// File: tb/tb_arcade_input_cond.sv
module tb_arcade_input_cond;

  localparam int NP  = 2;
  localparam int DEB = 4;
  localparam int CPC = 8;
  localparam int AFD = 3;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] joy_i   = '1;
  logic [1:0]  mode_i  = 2'd1;
  logic [1:0]  autofire_en_i = 2'b00;
  logic [7:0]  dir_n_o;
  logic [1:0]  btn_n_o, start_n_o, coin_n_o, coin_busy_o;

  arcade_input_cond #(
    .NUM_PLAYERS(NP), .NUM_BUTTONS(1), .START_BIT(5), .COIN_BIT(7),
    .DEBOUNCE_CYC(DEB), .COIN_PULSE_CYC(CPC), .AUTOFIRE_DIV(AFD)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .joy_i(joy_i), .mode_i(mode_i),
    .autofire_en_i(autofire_en_i), .dir_n_o(dir_n_o), .btn_n_o(btn_n_o),
    .start_n_o(start_n_o), .coin_n_o(coin_n_o), .coin_busy_o(coin_busy_o)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each conditioned bit (k: 0 button0, 1 start, 2 coin) flips once its last
  // DEB samples all disagree with the committed value. Coins are a schedule
  // of pulse start edges; autofire phase is derived from edges since press.
  int          n_edge;
  logic [DEB-1:0] win [NP][3];
  bit          stab [NP][3];
  int          rise_e [NP];
  int          last_s [NP];
  int          prev_s [NP];
  logic [7:0]  e_dir;
  logic [1:0]  e_btn, e_start, e_coin, e_busy;

  function automatic logic [15:0] view(input int p, input logic [31:0] joy, input logic [1:0] mode);
    logic [15:0] w, o;
    w = joy[16*p +: 16];
    if (mode == 2'd0) w = joy[15:0] | joy[31:16];
    else if (mode == 2'd2 && p >= 1) begin
      o = w;
      w[0] = o[1]; w[1] = o[0]; w[2] = o[3]; w[3] = o[2];
    end
    return w;
  endfunction

  task automatic model_reset();
    n_edge = 0;
    for (int p = 0; p < NP; p++) begin
      for (int k = 0; k < 3; k++) begin
        win[p][k]  = '0;
        stab[p][k] = 1'b0;
      end
      rise_e[p] = 0;
      last_s[p] = -1000;
      prev_s[p] = -1000;
    end
    e_dir = '1; e_btn = '1; e_start = '1; e_coin = '1; e_busy = '0;
  endtask

  task automatic coin_rise(input int p, input int n);
    int ns;
    if (n >= last_s[p] + 2*CPC) ns = n;
    else if (last_s[p] > n)     ns = -1;        // one already pending: dropped
    else                        ns = last_s[p] + 2*CPC;
    if (ns >= 0) begin
      prev_s[p] = last_s[p];
      last_s[p] = ns;
    end
  endtask

  task automatic model_step(input logic [31:0] joy, input logic [1:0] mode, input logic [1:0] en);
    logic [15:0] w;
    logic [2:0]  r;
    bit          held, ph;
    int          n;
    n = n_edge;
    for (int p = 0; p < NP; p++) begin
      w = view(p, joy, mode);
      e_dir[4*p +: 4] = ~w[3:0];
      held = stab[p][0];
      ph   = (((n - 1 - rise_e[p]) / AFD) % 2) == 0;
      e_btn[p]   = ~(en[p] ? (held & ph) : held);
      e_start[p] = ~stab[p][1];
      r = {w[7], w[5], w[4]};
      for (int k = 0; k < 3; k++) begin
        win[p][k] = {win[p][k][DEB-2:0], r[k]};
        if (win[p][k] == {DEB{~stab[p][k]}}) begin
          stab[p][k] = ~stab[p][k];
          if (stab[p][k]) begin
            if (k == 0) rise_e[p] = n;
            if (k == 2) coin_rise(p, n);
          end
        end
      end
      e_coin[p] = 1'b1;
      e_busy[p] = 1'b0;
      if ((last_s[p] <= n && n < last_s[p] + CPC) || (prev_s[p] <= n && n < prev_s[p] + CPC))
        e_coin[p] = 1'b0;
      if ((last_s[p] <= n && n < last_s[p] + 2*CPC) || (prev_s[p] <= n && n < prev_s[p] + 2*CPC))
        e_busy[p] = 1'b1;
    end
    n_edge++;
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    model_step(joy_i, mode_i, autofire_en_i);
    #1;
    chk("dir",   dir_n_o,     e_dir);
    chk("btn",   btn_n_o,     e_btn);
    chk("start", start_n_o,   e_start);
    chk("coin",  coin_n_o,    e_coin);
    chk("busy",  coin_busy_o, e_busy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first, lows, falls, saw;
    logic prev;
    logic [20:0] lv;
    int idx_tab [7] = '{0, 1, 2, 3, 4, 5, 7};

    // reset held with every joy bit set
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_dir",   dir_n_o,     8'hFF);
    chk("rst_btn",   btn_n_o,     2'b11);
    chk("rst_start", start_n_o,   2'b11);
    chk("rst_coin",  coin_n_o,    2'b11);
    chk("rst_busy",  coin_busy_o, 2'b00);
    @(negedge clk_sys);
    reset_n = 1'b1;
    model_reset();
    first = -1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (first < 0 && coin_n_o[0] == 1'b0) first = i;
    end
    chk("rst_coin_after_debounce", first, 3);
    joy_i = '0;
    repeat (40) cyc();

    // short glitch is filtered, long press lands DEB+1 edges later
    saw = 0;
    joy_i[4] = 1'b1;
    repeat (3) begin cyc(); if (btn_n_o[0] == 1'b0) saw = 1; end
    joy_i[4] = 1'b0;
    repeat (10) begin cyc(); if (btn_n_o[0] == 1'b0) saw = 1; end
    chk("glitch_filtered", saw, 0);
    joy_i[4] = 1'b1;
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (first < 0 && btn_n_o[0] == 1'b0) first = i;
    end
    chk("debounce_latency", first, 5);
    joy_i[4] = 1'b0;
    repeat (10) cyc();

    // held coin: one pulse, fixed width
    lows = 0; falls = 0; prev = 1'b1;
    joy_i[7] = 1'b1;
    repeat (100) begin
      cyc();
      if (coin_n_o[0] == 1'b0) lows++;
      if (prev && !coin_n_o[0]) falls++;
      prev = coin_n_o[0];
    end
    chk("coin_width", lows, 8);
    chk("coin_pulses", falls, 1);
    joy_i[7] = 1'b0;
    repeat (30) cyc();

    // second press during the gap replays right after it
    lows = 0; falls = 0; prev = 1'b1;
    for (int ph = 0; ph < 4; ph++) begin
      joy_i[7] = (ph % 2 == 0) && (ph < 3);
      repeat ((ph == 3) ? 40 : 5) begin
        cyc();
        if (coin_n_o[0] == 1'b0) lows++;
        if (prev && !coin_n_o[0]) falls++;
        prev = coin_n_o[0];
      end
    end
    chk("coin_two_width", lows, 16);
    chk("coin_two_pulses", falls, 2);

    // routing modes
    joy_i = '0;
    joy_i[16+3] = 1'b1;
    mode_i = 2'd0; cyc(); chk("mode_shared", dir_n_o, 8'h77);
    mode_i = 2'd2; cyc(); chk("mode_cocktail", dir_n_o, 8'hBF);
    mode_i = 2'd1; cyc(); chk("mode_indep", dir_n_o, 8'h7F);
    joy_i = '0;
    repeat (10) cyc();

    // autofire on player 0
    autofire_en_i = 2'b01;
    joy_i[4] = 1'b1;
    lv = '1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      lv[i] = btn_n_o[0];
    end
    for (int i = 1; i <= 20; i++)
      chk($sformatf("af_%0d", i), lv[i], (i < 5) ? 1 : (((i - 5) / AFD) % 2));
    joy_i[4] = 1'b0;
    repeat (10) cyc();
    autofire_en_i = 2'b00;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        joy_i[16*$urandom_range(0, 1) + idx_tab[$urandom_range(0, 6)]] ^= 1'b1;
      if ($urandom_range(0, 63) == 0) mode_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) autofire_en_i = 2'($urandom_range(0, 3));
      cyc();
    end

    // async reset in the middle of a pulse
    joy_i = '0; mode_i = 2'd1; autofire_en_i = 2'b00;
    repeat (50) cyc();
    joy_i[7] = 1'b1;
    saw = 0;
    for (int i = 0; i < 20 && saw == 0; i++) begin
      cyc();
      if (coin_n_o[0] == 1'b0) saw = 1;
    end
    chk("pulse_started", saw, 1);
    repeat (2) cyc();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_coin", coin_n_o, 2'b11);
    chk("async_rst_busy", coin_busy_o, 2'b00);
    joy_i = '0;
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    model_reset();
    cyc();
    chk("idle_after_rst", coin_busy_o, 2'b00);
    repeat (20) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
